uart_reg_readback_tx: RTL and testbench

UART transmitter that reads back register-bank contents to the host, mirroring the 8N1 receive path that writes the register bank.
- On a single-read or dump request it fetches register bytes through an address/data port and serialises a framed response on tx_out.
- Frame layout: header, count, (addr, data) pairs, XOR checksum.
- Sits beside the register bank at the top level; tx_out drives a dedicated output pin.

---
 rtl/uart_reg_readback_tx_if.sv | 23 ++
 rtl/uart_reg_readback_tx.sv | 188 ++++++++++++++++++
 tb/tb_uart_reg_readback_tx.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_reg_readback_tx_if.sv
// Request and register-bank port bundle for the UART readback transmitter.
// The slave side is the transmitter; the master side is the host plus bank.
interface uart_reg_readback_tx_if #(
   parameter int unsigned ADDR_W = 3
) ();
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              dump_req;
   logic [ADDR_W-1:0] reg_addr;
   logic [7:0]        reg_data;
   logic              busy;
   logic              done;

   modport master (
      output rd_req, rd_addr, dump_req, reg_data,
      input  reg_addr, busy, done
   );

   modport slave (
      input  rd_req, rd_addr, dump_req, reg_data,
      output reg_addr, busy, done
   );
endinterface

// File: rtl/uart_reg_readback_tx.sv
// 8N1 UART transmitter that reads register-bank bytes and sends them as a
// framed response: header, count, (addr, data) pairs, XOR checksum.
module uart_reg_readback_tx #(
   parameter int unsigned CLKS_PER_BIT = 142,
   parameter int unsigned ADDR_W       = 3,
   parameter logic [7:0]  HEADER       = 8'hA5
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   uart_reg_readback_tx_if.slave  bus,
   output logic                   tx_out
);

   localparam int unsigned CntW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned PairW = ADDR_W + 1;
   localparam int unsigned NRegs = 2 ** ADDR_W;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
   typedef enum logic [2:0] {KHeader, KCount, KAddr, KData, KChk} kind_e;

   state_e             state_q, state_d;
   kind_e              kind_q, kind_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [2:0]         bit_q, bit_d;
   logic [PairW-1:0]   pair_q, pair_d;
   logic [7:0]         shift_q, shift_d;
   logic [7:0]         chk_q, chk_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
   logic               dump_q, dump_d;
   logic               tx_q, tx_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               cnt_wrap;
   logic [PairW-1:0]   pair_nxt;
   logic [7:0]         cur_byte;
   logic [7:0]         byte_w;

   always_comb begin
      cur_byte = HEADER;
      unique case (kind_q)
         KHeader: cur_byte = HEADER;
         KCount:  cur_byte = dump_q ? 8'(NRegs) : 8'd1;
         KAddr:   cur_byte = 8'(addr_q);
         KData:   cur_byte = bus.reg_data;
         KChk:    cur_byte = chk_q;
         default: cur_byte = HEADER;
      endcase
   end

   // Bytes are latched on the first cycle of their start bit, so reg_data is
   // sampled a full byte-time after reg_addr moved.
   assign byte_w   = (cnt_q == '0) ? cur_byte : shift_q;
   assign cnt_wrap = (cnt_q == CntW'(CLKS_PER_BIT - 1));
   assign pair_nxt = pair_q + PairW'(1);

   always_comb begin
      state_d   = state_q;
      kind_d    = kind_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      pair_d    = pair_q;
      shift_d   = shift_q;
      chk_d     = chk_q;
      addr_d    = addr_q;
      rd_addr_d = rd_addr_q;
      dump_d    = dump_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      if (state_q != StIdle) begin
         cnt_d = cnt_wrap ? '0 : cnt_q + CntW'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (bus.dump_req || bus.rd_req) begin
               state_d = StStart;
               kind_d  = KHeader;
               cnt_d   = '0;
               pair_d  = '0;
               chk_d   = '0;
               dump_d  = bus.dump_req;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               if (!bus.dump_req) begin
                  rd_addr_d = bus.rd_addr;
               end
            end
         end
         StStart: begin
            if (cnt_q == '0) begin
               shift_d = cur_byte;
               chk_d   = chk_q ^ cur_byte;
            end
            if (cnt_wrap) begin
               state_d = StData;
               bit_d   = '0;
               tx_d    = byte_w[0];
               shift_d = byte_w >> 1;
            end
         end
         StData: begin
            if (cnt_wrap) begin
               if (bit_q == 3'd7) begin
                  state_d = StStop;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end
         end
         StStop: begin
            if (cnt_wrap) begin
               state_d = StStart;
               tx_d    = 1'b0;
               unique case (kind_q)
                  KHeader: kind_d = KCount;
                  KCount: begin
                     kind_d = KAddr;
                     addr_d = dump_q ? pair_q[ADDR_W-1:0] : rd_addr_q;
                  end
                  KAddr: kind_d = KData;
                  KData: begin
                     pair_d = pair_nxt;
                     if (!dump_q || (pair_nxt == PairW'(NRegs))) begin
                        kind_d = KChk;
                     end else begin
                        kind_d = KAddr;
                        addr_d = pair_nxt[ADDR_W-1:0];
                     end
                  end
                  KChk: begin
                     state_d = StIdle;
                     tx_d    = 1'b1;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
                  default: kind_d = KHeader;
               endcase
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= StIdle;
         kind_q    <= KHeader;
         cnt_q     <= '0;
         bit_q     <= '0;
         pair_q    <= '0;
         shift_q   <= '0;
         chk_q     <= '0;
         addr_q    <= '0;
         rd_addr_q <= '0;
         dump_q    <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         pair_q    <= pair_d;
         shift_q   <= shift_d;
         chk_q     <= chk_d;
         addr_q    <= addr_d;
         rd_addr_q <= rd_addr_d;
         dump_q    <= dump_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign tx_out       = tx_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.reg_addr = addr_q;

endmodule

// File: tb/tb_uart_reg_readback_tx.sv
// Scoreboard bench: stimulus pushes expected bytes and frame lengths, UART RX
// and frame monitors pop and compare independently.
module tb_uart_reg_readback_tx;

   localparam int unsigned CpbA = 8;
   localparam int unsigned CpbB = 142;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx_a, tx_b;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] exp_q[$];
   int         len_q[$];
   logic [2:0] addr_log[$];
   logic [7:0] bank[8];

   always #5 clk = ~clk;

   uart_reg_readback_tx_if #(.ADDR_W(3)) bus_a ();
   uart_reg_readback_tx_if #(.ADDR_W(3)) bus_b ();

   assign bus_a.reg_data = bank[bus_a.reg_addr];
   assign bus_b.reg_data = (bus_b.reg_addr == 3'd3) ? 8'h5C : 8'h00;

   uart_reg_readback_tx #(
      .CLKS_PER_BIT(CpbA),
      .ADDR_W(3),
      .HEADER(8'hA5)
   ) dut_a (
      .clk_in(clk),
      .rst_in(rst),
      .bus(bus_a),
      .tx_out(tx_a)
   );

   uart_reg_readback_tx dut_b (
      .clk_in(clk),
      .rst_in(rst),
      .bus(bus_b),
      .tx_out(tx_b)
   );

   always @(bus_a.reg_addr) addr_log.push_back(bus_a.reg_addr);

   function automatic logic sig_tx(input int sel);
      return (sel == 0) ? tx_a : tx_b;
   endfunction
   function automatic logic sig_busy(input int sel);
      return (sel == 0) ? bus_a.busy : bus_b.busy;
   endfunction
   function automatic logic sig_done(input int sel);
      return (sel == 0) ? bus_a.done : bus_b.done;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // UART receiver: samples mid-bit; bytes cut short by a reset are discarded.
   task automatic rx_mon(input int sel, input int cpb);
      logic [7:0] b;
      logic [7:0] e;
      logic       stop_bit;
      bit         aborted;
      forever begin
         @(negedge clk);
         if (sig_tx(sel) === 1'b0 && !rst) begin
            aborted = 1'b0;
            repeat (cpb / 2) begin
               @(negedge clk);
               if (rst) aborted = 1'b1;
            end
            for (int i = 0; i < 8; i++) begin
               repeat (cpb) begin
                  @(negedge clk);
                  if (rst) aborted = 1'b1;
               end
               b[i] = sig_tx(sel);
            end
            repeat (cpb) begin
               @(negedge clk);
               if (rst) aborted = 1'b1;
            end
            stop_bit = sig_tx(sel);
            if (!aborted) begin
               check("stop_bit", {31'd0, stop_bit}, 32'd1);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rx_byte: got unexpected byte %0h, expected none", b);
               end else begin
                  e = exp_q.pop_front();
                  check("rx_byte", {24'd0, b}, {24'd0, e});
               end
            end
         end
      end
   endtask

   // Frame monitor: busy length, done pulse, bit-boundary alignment.
   task automatic frm_mon(input int sel, input int cpb);
      int   cnt = 0;
      int   bad = 0;
      int   e;
      bit   rst_seen = 1'b0;
      logic ptx = 1'b1;
      forever begin
         @(negedge clk);
         if (rst && sig_busy(sel) === 1'b1) rst_seen = 1'b1;
         if (sig_busy(sel) === 1'b1) begin
            cnt++;
            if (sig_tx(sel) !== ptx && ((cnt - 1) % cpb) != 0) bad++;
            if (sig_done(sel) === 1'b1) bad++;
         end else if (cnt > 0) begin
            if (rst_seen) begin
               check("abort_no_done", {31'd0, sig_done(sel)}, 32'd0);
            end else begin
               check("done_pulse", {31'd0, sig_done(sel)}, 32'd1);
               check("bit_align", bad, 0);
               if (len_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL busy_len: got unexpected frame of %0d, expected none", cnt);
               end else begin
                  e = len_q.pop_front();
                  check("busy_len", cnt, e);
               end
            end
            cnt      = 0;
            bad      = 0;
            rst_seen = 1'b0;
         end else if (sig_done(sel) === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL spurious_done: got 1, expected 0");
         end
         ptx = sig_tx(sel);
      end
   endtask

   initial rx_mon(0, CpbA);
   initial rx_mon(1, CpbB);
   initial frm_mon(0, CpbA);
   initial frm_mon(1, CpbB);

   task automatic push_single(input logic [2:0] a, input logic [7:0] d, input int cpb);
      logic [7:0] bytes[5];
      bytes[0] = 8'hA5;
      bytes[1] = 8'h01;
      bytes[2] = {5'd0, a};
      bytes[3] = d;
      bytes[4] = bytes[0] ^ bytes[1] ^ bytes[2] ^ bytes[3];
      for (int i = 0; i < 5; i++) exp_q.push_back(bytes[i]);
      len_q.push_back(10 * cpb * 5);
   endtask

   task automatic push_dump();
      logic [7:0] c;
      c = 8'hA5 ^ 8'h08;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h08);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(8'(i));
         exp_q.push_back(bank[i]);
         c = c ^ 8'(i) ^ bank[i];
      end
      exp_q.push_back(c);
      len_q.push_back(10 * CpbA * 19);
   endtask

   task automatic req(input int sel, input bit rd, input bit dump, input logic [2:0] a);
      @(posedge clk);
      #1;
      if (sel == 0) begin
         bus_a.rd_req = rd; bus_a.dump_req = dump; bus_a.rd_addr = a;
      end else begin
         bus_b.rd_req = rd; bus_b.dump_req = dump; bus_b.rd_addr = a;
      end
      @(posedge clk);
      #1;
      bus_a.rd_req = 1'b0; bus_a.dump_req = 1'b0;
      bus_b.rd_req = 1'b0; bus_b.dump_req = 1'b0;
   endtask

   task automatic wait_done(input int sel, input int limit, input string name);
      for (int n = 0; n < limit; n++) begin
         @(negedge clk);
         if (sig_done(sel) === 1'b1) return;
      end
      checks++;
      errors++;
      $display("FAIL %s: got no done_out within %0d cycles, expected a pulse", name, limit);
   endtask

   task automatic check_addr_steps(input string name);
      bit ok;
      ok = (addr_log.size() == 8);
      for (int i = 0; i < addr_log.size() && ok; i++) begin
         if (addr_log[i] != 3'(i)) ok = 1'b0;
      end
      check(name, {31'd0, ok}, 32'd1);
   endtask

   initial begin
      int viol;
      bus_a.rd_req = 1'b0; bus_a.dump_req = 1'b0; bus_a.rd_addr = '0;
      bus_b.rd_req = 1'b0; bus_b.dump_req = 1'b0; bus_b.rd_addr = '0;
      for (int i = 0; i < 8; i++) bank[i] = 8'h10 + 8'(i);
      bank[3] = 8'h5C;

      // Reset and idle
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx", {31'd0, tx_a}, 32'd1);
      check("rst_busy", {31'd0, bus_a.busy}, 32'd0);
      check("rst_done", {31'd0, bus_a.done}, 32'd0);
      check("rst_reg_addr", {29'd0, bus_a.reg_addr}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      viol = 0;
      repeat (1000) begin
         @(negedge clk);
         if (tx_a !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) viol++;
      end
      check("idle_1000", viol, 0);

      // Single read of reg 3 = 5C: A5 01 03 5C FB
      push_single(3'd3, 8'h5C, CpbA);
      req(0, 1'b1, 1'b0, 3'd3);
      wait_done(0, 600, "single_done");
      repeat (5) @(negedge clk);

      // Dump, regs hold 10+i
      bank[3] = 8'h13;
      addr_log.delete();
      push_dump();
      req(0, 1'b0, 1'b1, 3'd0);
      wait_done(0, 2000, "dump_done");
      check_addr_steps("dump_addr_steps");
      repeat (5) @(negedge clk);

      // Simultaneous rd and dump: dump wins
      addr_log.delete();
      push_dump();
      req(0, 1'b1, 1'b1, 3'd2);
      wait_done(0, 2000, "collide_done");
      check_addr_steps("collide_addr_steps");
      repeat (5) @(negedge clk);

      // Request while busy is dropped
      push_single(3'd5, 8'h15, CpbA);
      req(0, 1'b1, 1'b0, 3'd5);
      repeat (100) @(negedge clk);
      req(0, 1'b1, 1'b0, 3'd2);
      wait_done(0, 600, "busy_ign_done");
      viol = 0;
      repeat (300) begin
         @(negedge clk);
         if (bus_a.busy !== 1'b0) viol++;
      end
      check("busy_req_ignored", viol, 0);

      // Request in the done cycle is accepted with no gap
      push_single(3'd1, 8'h11, CpbA);
      push_single(3'd6, 8'h16, CpbA);
      req(0, 1'b1, 1'b0, 3'd1);
      wait_done(0, 600, "b2b_first_done");
      bus_a.rd_req  = 1'b1;
      bus_a.rd_addr = 3'd6;
      @(posedge clk);
      #1 bus_a.rd_req = 1'b0;
      @(negedge clk);
      check("b2b_busy", {31'd0, bus_a.busy}, 32'd1);
      check("b2b_start_bit", {31'd0, tx_a}, 32'd0);
      wait_done(0, 600, "b2b_second_done");
      repeat (5) @(negedge clk);

      // Reset during the addr byte's data bits
      push_single(3'd4, 8'h14, CpbA);
      req(0, 1'b1, 1'b0, 3'd4);
      repeat (180) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_tx", {31'd0, tx_a}, 32'd1);
      check("midrst_busy", {31'd0, bus_a.busy}, 32'd0);
      repeat (20) @(negedge clk);
      exp_q.delete();
      len_q.delete();
      repeat (100) @(negedge clk);
      push_single(3'd2, 8'h12, CpbA);
      req(0, 1'b1, 1'b0, 3'd2);
      wait_done(0, 600, "post_rst_done");
      repeat (5) @(negedge clk);

      // Default bit time: 7100 busy cycles
      push_single(3'd3, 8'h5C, CpbB);
      req(1, 1'b1, 1'b0, 3'd3);
      wait_done(1, 8000, "default_done");
      repeat (20) @(negedge clk);

      check("exp_bytes_drained", exp_q.size(), 0);
      check("exp_frames_drained", len_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
